sm_accumulator: RTL and testbench
=================================

Name: sm_accumulator

Overview:
- Streaming sign-magnitude accumulator: sums a frame of signed-magnitude operands (bit MAG_W = sign, 1 = negative) and emits one result per frame.
- Parametrised, clocked successor of the team's combinational 21-bit sign-magnitude adder. Adds valid/ready handshakes, frame delimiting, guard bits, an overflow flag and -0 normalisation.
- Sits between the datapath multiplier stage and the result buffer.

Parameters:
- MAG_W, 20, magnitude bits per operand and result; words are MAG_W+1 bits wide.
- GUARD_W, 4, extra magnitude bits in the internal accumulator.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  MAG_W+1  operand, sign-magnitude
- in_last  input  1  final beat of frame; qualified by in_valid
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  MAG_W+1  frame sum, sign-magnitude
- out_ovf  output  1  frame sum magnitude exceeded 2^MAG_W-1
- busy  output  1  frame in progress or result pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; accumulator = +0; sticky ovf = 0.
  - out_valid=0, out_data=0, out_ovf=0, busy=0.
  - in_ready=1 as soon as reset releases.
  - Reset mid-frame or mid-output discards all partial data; nothing is emitted.
- States IDLE, ACC, OUT:
  - in_ready=1 in IDLE/ACC, 0 in OUT.
  - busy=1 in ACC/OUT.
- Beat accepted when in_valid&&in_ready:
  - acc_next = acc (+) in_data, where (+) is the sign-magnitude add with the input magnitude zero-extended by GUARD_W.
  - in_last=0 -> go to ACC.
  - in_last=1 -> go to OUT; the result registers load from acc_next in the same edge.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - Throughput is one beat per cycle, with one bubble per frame (the OUT cycle).
  - Single-beat frames are legal.
- OUT state:
  - out_data and out_ovf are held stable until out_valid&&out_ready.
  - On that handshake: go to IDLE, clear acc and sticky ovf, drop out_valid.
  - in_valid during OUT is ignored; no beat is consumed.
- Sign-magnitude add rules:
  - Equal signs: add magnitudes, keep the sign.
  - Differing signs: subtract the smaller magnitude from the larger; result takes the sign of the larger magnitude.
  - Equal magnitudes give +0.
  - Any zero magnitude is forced to sign 0: -0 inputs are treated as +0 and -0 is never produced.
- Internal overflow:
  - If the accumulator magnitude would exceed 2^(MAG_W+GUARD_W)-1, it clamps to all ones and sticky ovf is set.
- Output overflow:
  - out_ovf=1 if sticky ovf is set or the final magnitude exceeds 2^MAG_W-1.
  - Without the optional feature, out_data = {sign, low MAG_W bits of magnitude}, normalised to +0 if those bits are zero.

Optional Feature:
- Macro: SM_ACC_SATURATE_EN.
- Defined: when out_ovf=1, out_data = {sign, all ones}, i.e. saturation to ±(2^MAG_W-1).
- Undefined: wrap/truncate as stated in Behaviour.
- out_ovf is identical in both builds.

Decomposition:
- Shared package sm_pkg holds:
  - SIGN_NEG=1'b1 and SIGN_POS=1'b0.
  - The state encodings IDLE/ACC/OUT.
  - A function for -0 normalisation.
- Sub-module sm_add:
  - Combinational, parameter W.
  - Sign-magnitude add of two (W+1)-bit words with carry-out as the overflow indication.
  - Instantiated once with W=MAG_W+GUARD_W.

Test Plan (MAG_W=20, GUARD_W=4):
- Assert rst_n=0 mid-frame after beat 0x000005 -> outputs 0 and busy=0. After release, frame {0x000003 last} yields out_data=0x000003; the earlier beat is discarded.
- Frame {0x000005, 0x100003 last} -> out_data=0x000002, out_ovf=0, out_valid one cycle after the last beat.
- Frame {0x100007, 0x000007 last} -> out_data=0x000000 (not 0x100000). Separately, frame {0x100000 last} -> out_data=0x000000.
- Frame {0x100004, 0x100006 last} -> out_data=0x10000A, out_ovf=0.
- Frame {0x0FFFFF, 0x000001 last} -> out_ovf=1:
  - macro undefined: out_data=0x000000.
  - SM_ACC_SATURATE_EN defined: out_data=0x0FFFFF.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> out_data stable, in_ready=0, no beat consumed. On out_ready=1 the block returns to IDLE; the next beat 0x000009 last gives 0x000009.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude accumulator.
package sm_pkg;

  localparam logic SIGN_NEG = 1'b1;
  localparam logic SIGN_POS = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // A zero magnitude always carries the positive sign.
  function automatic logic norm_sign(
    input logic s,
    input logic nz
  );
    return nz ? s : SIGN_POS;
  endfunction

endpackage

// File: rtl/sm_add.sv
// Combinational sign-magnitude adder of two (W+1)-bit words.
module sm_add
  import sm_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] sum,
  output logic       ovf
);

  logic [W-1:0] am, bm, m;
  logic         as, bs, s, c;

  assign am = a[W-1:0];
  assign bm = b[W-1:0];
  assign as = norm_sign(a[W], |am);
  assign bs = norm_sign(b[W], |bm);

  always_comb begin
    m = '0;
    s = SIGN_POS;
    c = 1'b0;
    unique case (1'b1)
      (as == bs): begin
        {c, m} = {1'b0, am} + {1'b0, bm};
        s      = as;
      end
      (as != bs && am >= bm): begin
        m = am - bm;
        s = as;
      end
      default: begin
        m = bm - am;
        s = bs;
      end
    endcase
  end

  assign sum = {norm_sign(s, |m), m};
  assign ovf = c;

endmodule

// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude frame accumulator with guard bits.
// Define SM_ACC_SATURATE_EN to saturate out_data on overflow.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int MAG_W   = 20,
  parameter int GUARD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int AW = MAG_W + GUARD_W;

  state_t state, state_n;

  logic          acc_s;
  logic [AW-1:0] acc_m;
  logic          sticky;

  logic [AW:0]   add_b, add_sum;
  logic          add_c;
  logic          take, take_last, drain;

  logic          nxt_s;
  logic [AW-1:0] nxt_m;
  logic          nxt_ovf;
  logic          fin_ovf;
  logic [MAG_W-1:0] low;
  logic [MAG_W:0]   fin_data;

  assign take      = in_valid && in_ready;
  assign take_last = take && in_last;
  assign drain     = out_valid && out_ready;

  assign add_b = {in_data[MAG_W], {GUARD_W{1'b0}}, in_data[MAG_W-1:0]};

  sm_add #(.W(AW)) u_add (
    .a   ({acc_s, acc_m}),
    .b   (add_b),
    .sum (add_sum),
    .ovf (add_c)
  );

  // Clamped magnitude is all ones, so its sign is never -0.
  assign nxt_m   = add_c ? '1 : add_sum[AW-1:0];
  assign nxt_s   = add_sum[AW];
  assign nxt_ovf = sticky | add_c;
  assign fin_ovf = nxt_ovf | (|nxt_m[AW-1:MAG_W]);
  assign low     = nxt_m[MAG_W-1:0];

  always_comb begin
    fin_data = '0;
`ifdef SM_ACC_SATURATE_EN
    if (fin_ovf)
      fin_data = {nxt_s, {MAG_W{1'b1}}};
    else
      fin_data = {norm_sign(nxt_s, |low), low};
`else
    fin_data = {norm_sign(nxt_s, |low), low};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, ACC: begin
        if (take_last)
          state_n = OUT;
        else if (take)
          state_n = ACC;
      end
      OUT: begin
        if (out_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != OUT);
    busy      = (state != IDLE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s  <= SIGN_POS;
      acc_m  <= '0;
      sticky <= 1'b0;
    end else if (drain) begin
      acc_s  <= SIGN_POS;
      acc_m  <= '0;
      sticky <= 1'b0;
    end else if (take) begin
      acc_s  <= nxt_s;
      acc_m  <= nxt_m;
      sticky <= nxt_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (take_last) begin
      out_data <= fin_data;
      out_ovf  <= fin_ovf;
    end
  end

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed bench for sm_accumulator (MAG_W=20, GUARD_W=4).
// Expectations follow SM_ACC_SATURATE_EN when defined.
module tb_sm_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] out_data;
  logic        out_ovf;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

`ifdef SM_ACC_SATURATE_EN
  localparam logic [20:0] OVF_POS = 21'h0FFFFF;
`else
  localparam logic [20:0] OVF_POS = 21'h000000;
`endif

  typedef struct {
    string             name;
    int                n;
    logic [2:0][20:0]  b;
    logic [20:0]       ed;
    logic              eo;
  } vec_t;

  vec_t vecs[8];

  sm_accumulator #(.MAG_W(20), .GUARD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string nm, input int n,
                              input logic [20:0] b0, input logic [20:0] b1,
                              input logic [20:0] b2, input logic [20:0] ed,
                              input logic eo);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.b[0] = b0;
    v.b[1] = b1;
    v.b[2] = b2;
    v.ed   = ed;
    v.eo   = eo;
    return v;
  endfunction

  task automatic beat(input string nm, input logic [20:0] d,
                      input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [20:0] ed,
                            input logic eo);
    check({nm, " out_valid"}, 32'(out_valid), 32'd1);
    check({nm, " in_ready_out"}, 32'(in_ready), 32'd0);
    check({nm, " busy"}, 32'(busy), 32'd1);
    check({nm, " data"}, 32'(out_data), 32'(ed));
    check({nm, " ovf"}, 32'(out_ovf), 32'(eo));
  endtask

  task automatic drain(input string nm);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({nm, " drained"}, 32'(out_valid), 32'd0);
    check({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = mk("diff_sign", 2, 21'h000005, 21'h100003, 0, 21'h000002, 0);
    vecs[1] = mk("cancel",    2, 21'h100007, 21'h000007, 0, 21'h000000, 0);
    vecs[2] = mk("neg_zero",  1, 21'h100000, 0, 0,          21'h000000, 0);
    vecs[3] = mk("both_neg",  2, 21'h100004, 21'h100006, 0, 21'h10000A, 0);
    vecs[4] = mk("ovf",       2, 21'h0FFFFF, 21'h000001, 0, OVF_POS,    1);
    vecs[5] = mk("neg_wins",  2, 21'h000003, 21'h100008, 0, 21'h100005, 0);
    vecs[6] = mk("pos_wins",  2, 21'h100001, 21'h0FFFFF, 0, 21'h0FFFFE, 0);
    vecs[7] = mk("guard",     3, 21'h0FFFFF, 21'h0FFFFF, 21'h1FFFFF,
                 21'h0FFFFF, 0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_ovf", 32'(out_ovf), 32'd0);

    // Reset mid-frame discards the partial sum.
    beat("mid", 21'h000005, 1'b0);
    check("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat("after_rst", 21'h000003, 1'b1);
    expect_out("after_rst", 21'h000003, 1'b0);
    drain("after_rst");

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        beat(vecs[i].name, vecs[i].b[k], k == vecs[i].n - 1);
        if (k < vecs[i].n - 1)
          check({vecs[i].name, " early"}, 32'(out_valid), 32'd0);
      end
      expect_out(vecs[i].name, vecs[i].ed, vecs[i].eo);
      drain(vecs[i].name);
    end

    // 17 max beats clamp the guard range; the sticky flag survives.
    for (int k = 0; k < 17; k++)
      beat("clamp", 21'h0FFFFF, 1'b0);
    beat("clamp", 21'h1FFFFF, 1'b1);
    expect_out("clamp", OVF_POS, 1'b1);
    drain("clamp");

    // Back-pressure: OUT ignores incoming beats.
    beat("bp", 21'h000004, 1'b1);
    in_valid = 1'b1;
    in_data  = 21'h000007;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp data", 32'(out_data), 32'h000004);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("bp");
    beat("bp_next", 21'h000009, 1'b1);
    expect_out("bp_next", 21'h000009, 1'b0);
    drain("bp_next");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
